// File: rtl/corr_window_scan.sv
// corr_window_scan: rasters correlation start coordinates over a window and tracks the best score.
module corr_window_scan #(
  parameter int WIN_W   = 16,
  parameter int WIN_H   = 16,
  parameter int STEP    = 1,
  parameter int COORD_W = 13,
  parameter int SCORE_W = 32
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic [COORD_W-1:0] iXorigin,
  input  logic [COORD_W-1:0] iYorigin,
  input  logic               iCorrFinished,
  input  logic [SCORE_W-1:0] iCorrScore,
  output logic [COORD_W-1:0] oXstart,
  output logic [COORD_W-1:0] oYstart,
  output logic               oBusy,
  output logic               oDone,
  output logic [SCORE_W-1:0] oBestScore,
  output logic [COORD_W-1:0] oBestX,
  output logic [COORD_W-1:0] oBestY
);
  localparam int IW = $clog2(WIN_W > WIN_H ? WIN_W : WIN_H) + 1;
  localparam logic [IW-1:0] XLAST = IW'(WIN_W - 1);
  localparam logic [IW-1:0] YLAST = IW'(WIN_H - 1);
  localparam logic [COORD_W-1:0] STEPC = COORD_W'(STEP);
  typedef enum logic [2:0] {IDLE, FLUSH, RUN, CAPTURE, DONE} state_t;
  state_t state, stateN;
  logic [COORD_W-1:0] originX, originY, originXN, originYN;
  logic [COORD_W-1:0] pendX, pendY, pendXN, pendYN;
  logic [COORD_W-1:0] xN, yN, bestXN, bestYN;
  logic [IW-1:0] cx, cy, cxN, cyN;
  logic [SCORE_W-1:0] bestScoreN;
  logic last, lastN, bestValid, bestValidN, busyN, doneN, atEnd, rowEnd;
  always_comb begin
    stateN = state;
    originXN = originX;
    originYN = originY;
    pendXN = pendX;
    pendYN = pendY;
    xN = oXstart;
    yN = oYstart;
    cxN = cx;
    cyN = cy;
    lastN = last;
    bestValidN = bestValid;
    bestScoreN = oBestScore;
    bestXN = oBestX;
    bestYN = oBestY;
    busyN = oBusy;
    doneN = 1'b0;
    atEnd = (cx == XLAST) && (cy == YLAST);
    rowEnd = cx == XLAST;
    case (state)
      IDLE: if (iStart) begin
        originXN = iXorigin;
        originYN = iYorigin;
        xN = iXorigin;
        yN = iYorigin;
        cxN = '0;
        cyN = '0;
        bestScoreN = '0;
        bestXN = '0;
        bestYN = '0;
        bestValidN = 1'b0;
        busyN = 1'b1;
        stateN = FLUSH;
      end
      FLUSH: stateN = iCorrFinished ? RUN : FLUSH;
      // New coordinate lands with the finish edge so the restarted correlation reads it from its first cycle.
      RUN: if (iCorrFinished) begin
        pendXN = oXstart;
        pendYN = oYstart;
        lastN = atEnd;
        cxN = atEnd ? cx : (rowEnd ? '0 : cx + IW'(1));
        cyN = atEnd ? cy : (rowEnd ? cy + IW'(1) : cy);
        xN = originX + COORD_W'(cxN) * STEPC;
        yN = originY + COORD_W'(cyN) * STEPC;
        stateN = CAPTURE;
      end
      CAPTURE: begin
        if (!bestValid || iCorrScore > oBestScore) begin
          bestScoreN = iCorrScore;
          bestXN = pendX;
          bestYN = pendY;
          bestValidN = 1'b1;
        end
        stateN = last ? DONE : RUN;
        doneN = last;
        busyN = !last;
      end
      DONE: stateN = IDLE;
      default: stateN = IDLE;
    endcase
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      originX <= '0;
      originY <= '0;
      pendX <= '0;
      pendY <= '0;
      cx <= '0;
      cy <= '0;
      last <= 1'b0;
      bestValid <= 1'b0;
      oXstart <= '0;
      oYstart <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oBestScore <= '0;
      oBestX <= '0;
      oBestY <= '0;
    end else begin
      state <= stateN;
      originX <= originXN;
      originY <= originYN;
      pendX <= pendXN;
      pendY <= pendYN;
      cx <= cxN;
      cy <= cyN;
      last <= lastN;
      bestValid <= bestValidN;
      oXstart <= xN;
      oYstart <= yN;
      oBusy <= busyN;
      oDone <= doneN;
      oBestScore <= bestScoreN;
      oBestX <= bestXN;
      oBestY <= bestYN;
    end
  end
endmodule

// File: doc/corr_window_scan.md
Name: corr_window_scan

Overview:
- Sequencer for the correlation-score datapath. The datapath free-runs: it raises a one-cycle finished pulse, restarts, and reads its start coordinates live.
- On a start request, this block rasters the datapath's start coordinate over a WIN_W x WIN_H grid of candidate positions anchored at a latched origin.
- It discards the correlation that was already in flight, captures each completed score, and reports the best score and its position.
- It sits between the camera/control logic and the correlation-score datapath.

Parameters:
- WIN_W, 16, number of candidate X positions per row (>=1)
- WIN_H, 16, number of candidate rows (>=1)
- STEP, 1, coordinate increment between adjacent candidates (X and Y)
- COORD_W, 13, coordinate width
- SCORE_W, 32, score width

Ports:
- iCLK  in  1  system clock (50 MHz)
- iRST  in  1  asynchronous, active-high reset
- iStart  in  1  one-cycle scan request; honoured only in IDLE
- iXorigin  in  COORD_W  X of first candidate; sampled with iStart
- iYorigin  in  COORD_W  Y of first candidate; sampled with iStart
- iCorrFinished  in  1  datapath finished pulse, high one cycle
- iCorrScore  in  SCORE_W  datapath score; valid the cycle after iCorrFinished
- oXstart  out  COORD_W  start X driven to the datapath
- oYstart  out  COORD_W  start Y driven to the datapath
- oBusy  out  1  high from accepted iStart until oDone
- oDone  out  1  one-cycle pulse when the scan completes
- oBestScore  out  SCORE_W  highest captured score
- oBestX  out  COORD_W  X of the best candidate
- oBestY  out  COORD_W  Y of the best candidate

Behaviour:
- Reset (async, any state): state=IDLE. All outputs, counters and pending registers are 0. The best-valid flag is cleared.
- States: IDLE, FLUSH, RUN, CAPTURE, DONE.
- IDLE:
  - On iStart, latch the origin; set oXstart=iXorigin, oYstart=iYorigin.
  - Clear the cx/cy indices, oBestScore/oBestX/oBestY and the best-valid flag; oBusy=1; go to FLUSH.
  - oBest* hold their values in IDLE until the next accepted start.
- FLUSH:
  - The first iCorrFinished after start ends a correlation computed with stale or changing coordinates. Ignore its score; go to RUN.
  - oXstart/oYstart stay at the origin.
- RUN:
  - oXstart/oYstart are held stable for the whole correlation.
  - On iCorrFinished, in the same clock edge:
    - pendX<=oXstart, pendY<=oYstart; last<=(cx==WIN_W-1 && cy==WIN_H-1).
    - If not last, advance the indices: cx+1, or cx=0 and cy+1 at row end.
    - Update oXstart=originX+cx'*STEP and oYstart=originY+cy'*STEP, so the new coordinate is in place on the datapath's first read cycle.
    - Go to CAPTURE.
  - If last, the coordinates are held.
- CAPTURE (exactly one cycle):
  - Sample iCorrScore.
  - If the best-valid flag is clear, or iCorrScore > oBestScore (unsigned, strict), then oBestScore<=iCorrScore, oBestX<=pendX, oBestY<=pendY, and the best-valid flag is set.
  - Ties keep the earlier candidate in raster order.
  - Next state: DONE if last, else RUN.
- DONE (one cycle): oDone=1, oBusy=0; go to IDLE. oDone is a registered pulse of exactly one cycle.
- Arithmetic:
  - Coordinate sums are COORD_W wide and wrap modulo 2^COORD_W; no saturation.
  - Index counters are sized clog2(max(WIN_W,WIN_H))+1.
- Spurious events:
  - iCorrFinished in IDLE, CAPTURE or DONE is ignored. The datapath period makes a finish in CAPTURE impossible; the bench asserts that it never occurs.
  - iStart outside IDLE is ignored; no restart or queueing.
- Latency:
  - Total scan time is (WIN_W*WIN_H+1) datapath periods, plus CAPTURE/DONE overhead.
  - oBest* are final on the cycle oDone is high.

Test Plan:
- Reset mid-scan: assert iRST during RUN after 3 captures -> outputs 0 immediately, state IDLE, subsequent finished pulses ignored, no oDone.
- 2x2 window, origin (10,20), STEP=1; behavioural datapath returns scores 5,9,9,3 (after the flushed first finish, whose fake score 999 is ignored) -> oDone once; oBestScore=9, oBestX=11, oBestY=20 (tie keeps earlier); oXstart/oYstart sequence (10,20),(11,20),(10,21),(11,21).
- Coordinate timing: check that oXstart changes on the cycle following iCorrFinished, never mid-correlation; sequence per row (10,20)->(11,20), wrap to the next row correctly.
- All-zero scores, 3x1 window -> best-valid path selects the first candidate: oBestScore=0, oBestX=origin X.
- STEP=4, origin X=8190 (13-bit), WIN_W=2 -> second candidate oXstart=2 (wrap); best reported with the wrapped coordinate.
- iStart pulsed during RUN and held high in DONE -> the running scan is unaffected; a new scan starts only from IDLE; oBest* are cleared only at the accepted start.
